video_mode_sequencer: RTL and testbench



---
 rtl/video_seq_pkg.sv | 29 ++
 rtl/vsync_frame_tick.sv | 46 ++++
 rtl/video_mode_sequencer.sv | 156 +++++++++++++++
 tb/tb_video_mode_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_seq_pkg.sv
// Shared definitions for the video mode sequencer: config field layout,
// sequencer state encoding and the mask of fields that disturb sync/timing.
package video_seq_pkg;

   localparam int CFG_W     = 7;
   localparam int SD_DIS_B  = 6;
   localparam int YPBPR_B   = 5;
   localparam int SCAN_HI   = 4;
   localparam int SCAN_LO   = 3;
   localparam int BLEND_B   = 2;
   localparam int ROT_HI    = 1;
   localparam int ROT_LO    = 0;

   localparam logic [CFG_W-1:0] SLOW_MASK = 7'b1111000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FAST   = 3'd1,
      ST_PRE    = 3'd2,
      ST_APPLY  = 3'd3,
      ST_SETTLE = 3'd4
   } seq_state_e;

   // True when moving from cur to nxt touches a field that alters sync or timing.
   function automatic logic is_slow(input logic [CFG_W-1:0] nxt, input logic [CFG_W-1:0] cur);
      return |((nxt ^ cur) & SLOW_MASK);
   endfunction

endpackage

// File: rtl/vsync_frame_tick.sv
// Frame tick generator: one-cycle pulse on each VSync leading edge, or a
// synthetic tick when no edge has been seen for VS_TIMEOUT cycles.
module vsync_frame_tick #(
   parameter int VS_TIMEOUT    = 1048576,
   parameter bit VS_ACTIVE_LOW = 1'b1
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic vsync_in,
   output logic tick
);

   localparam int TO_W = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;

   logic            vs_prev_r;
   logic [TO_W-1:0] to_cnt_r;
   logic            edge_s;
   logic            timeout_s;

   // Leading-edge detect and timeout compare.
   always_comb begin
      if (VS_ACTIVE_LOW) begin
         edge_s = vs_prev_r & ~vsync_in;
      end else begin
         edge_s = ~vs_prev_r & vsync_in;
      end
      timeout_s = (to_cnt_r == TO_W'(VS_TIMEOUT - 1));
      tick      = edge_s | timeout_s;
   end

   // History starts at the inactive level so reset release cannot fake an edge.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev_r <= VS_ACTIVE_LOW;
         to_cnt_r  <= '0;
      end else begin
         vs_prev_r <= vsync_in;
         if (tick) begin
            to_cnt_r <= '0;
         end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end
      end
   end

endmodule

// File: rtl/video_mode_sequencer.sv
// Debounces mode requests and applies them on frame boundaries, blanking the
// picture around changes that disturb sync or timing.
module video_mode_sequencer
   import video_seq_pkg::*;
#(
   parameter int               STABLE_CYCLES = 16,
   parameter int               VS_TIMEOUT    = 1048576,
   parameter int               PRE_FRAMES    = 1,
   parameter int               SETTLE_FRAMES = 2,
   parameter logic [CFG_W-1:0] RESET_CFG     = 7'b0000000,
   parameter bit               VS_ACTIVE_LOW = 1'b1
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       req_scandoubler_disable,
   input  logic       req_ypbpr,
   input  logic [1:0] req_scanlines,
   input  logic       req_blend,
   input  logic [1:0] req_rotate,
   input  logic       vsync_in,
   output logic       scandoubler_disable,
   output logic       ypbpr,
   output logic [1:0] scanlines,
   output logic       blend,
   output logic [1:0] rotate,
   output logic       blank,
   output logic       busy
);

   localparam int SC_W = $clog2(STABLE_CYCLES + 1);
   localparam int FC_W = $clog2(PRE_FRAMES + SETTLE_FRAMES + 2);

   logic [CFG_W-1:0] req_cfg_s;
   logic [CFG_W-1:0] req_prev_r;
   logic [CFG_W-1:0] stab_cfg_r;
   logic [CFG_W-1:0] act_cfg_r;
   logic [SC_W-1:0]  stab_cnt_r;
   logic [FC_W-1:0]  frame_cnt_r;
   logic             blank_r;
   logic             busy_r;
   logic             tick_s;
   seq_state_e       state_r;

   assign req_cfg_s = {req_scandoubler_disable, req_ypbpr, req_scanlines, req_blend, req_rotate};

   assign scandoubler_disable = act_cfg_r[SD_DIS_B];
   assign ypbpr               = act_cfg_r[YPBPR_B];
   assign scanlines           = act_cfg_r[SCAN_HI:SCAN_LO];
   assign blend               = act_cfg_r[BLEND_B];
   assign rotate              = act_cfg_r[ROT_HI:ROT_LO];
   assign blank               = blank_r;
   assign busy                = busy_r;

   vsync_frame_tick #(
      .VS_TIMEOUT    (VS_TIMEOUT),
      .VS_ACTIVE_LOW (VS_ACTIVE_LOW)
   ) u_tick (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .vsync_in (vsync_in),
      .tick     (tick_s)
   );

   // Stability filter: a request is accepted the cycle its run length hits STABLE_CYCLES.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         req_prev_r <= RESET_CFG;
         stab_cfg_r <= RESET_CFG;
         stab_cnt_r <= '0;
      end else begin
         req_prev_r <= req_cfg_s;
         if (req_cfg_s != req_prev_r) begin
            stab_cnt_r <= '0;
         end else if (stab_cnt_r != SC_W'(STABLE_CYCLES)) begin
            stab_cnt_r <= stab_cnt_r + SC_W'(1);
         end
         if ((req_cfg_s == req_prev_r) && (int'(stab_cnt_r) >= STABLE_CYCLES - 32'sd1)) begin
            stab_cfg_r <= req_cfg_s;
         end
      end
   end

   // Sequencer: fast changes wait one tick, slow changes run PRE/APPLY/SETTLE under blank.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         act_cfg_r   <= RESET_CFG;
         blank_r     <= 1'b0;
         busy_r      <= 1'b0;
         frame_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (stab_cfg_r != act_cfg_r) begin
                  busy_r      <= 1'b1;
                  frame_cnt_r <= '0;
                  if (is_slow(stab_cfg_r, act_cfg_r)) begin
                     state_r <= ST_PRE;
                     blank_r <= 1'b1;
                  end else begin
                     state_r <= ST_FAST;
                  end
               end
            end
            ST_FAST: begin
               if (tick_s) begin
                  act_cfg_r <= stab_cfg_r;
                  state_r   <= ST_IDLE;
                  busy_r    <= 1'b0;
               end
            end
            ST_PRE: begin
               if (PRE_FRAMES == 0) begin
                  state_r <= ST_APPLY;
               end else if (tick_s) begin
                  if (int'(frame_cnt_r) >= PRE_FRAMES - 32'sd1) begin
                     state_r <= ST_APPLY;
                  end else begin
                     frame_cnt_r <= frame_cnt_r + FC_W'(1);
                  end
               end
            end
            ST_APPLY: begin
               act_cfg_r   <= stab_cfg_r;
               frame_cnt_r <= '0;
               state_r     <= ST_SETTLE;
            end
            ST_SETTLE: begin
               // A newer accepted request restarts the sequence without releasing blank.
               if (stab_cfg_r != act_cfg_r) begin
                  state_r     <= ST_PRE;
                  frame_cnt_r <= '0;
               end else if (SETTLE_FRAMES == 0) begin
                  state_r <= ST_IDLE;
                  blank_r <= 1'b0;
                  busy_r  <= 1'b0;
               end else if (tick_s) begin
                  if (int'(frame_cnt_r) >= SETTLE_FRAMES - 32'sd1) begin
                     state_r <= ST_IDLE;
                     blank_r <= 1'b0;
                     busy_r  <= 1'b0;
                  end else begin
                     frame_cnt_r <= frame_cnt_r + FC_W'(1);
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               blank_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Self-checking bench: directed scenarios plus random requests, compared every
// cycle against a frame-countdown reference model of the sequencing rules.
module tb_video_mode_sequencer;

   localparam int STABLE   = 4;
   localparam int TIMEOUT  = 1000;
   localparam int PRE_F    = 1;
   localparam int SETTLE_F = 2;
   localparam int VS_PER   = 200;

   localparam int M_IDLE   = 0;
   localparam int M_FAST   = 1;
   localparam int M_PRE    = 2;
   localparam int M_APPLY  = 3;
   localparam int M_SETTLE = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_sd = 1'b0;
   logic       req_ypbpr = 1'b0;
   logic [1:0] req_scan = 2'd0;
   logic       req_blend = 1'b0;
   logic [1:0] req_rot = 2'd0;
   logic       vsync = 1'b1;
   logic       sd_o, ypbpr_o, blend_o, blank_o, busy_o;
   logic [1:0] scan_o, rot_o;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [6:0] m_prev_req, m_acc, m_act;
   int         m_age, m_quiet, m_phase, m_left;
   logic       m_vs_prev, m_blank, m_busy;
   bit         vs_run = 1'b1;
   int         vs_ctr = 50;

   video_mode_sequencer #(
      .STABLE_CYCLES (STABLE),
      .VS_TIMEOUT    (TIMEOUT),
      .PRE_FRAMES    (PRE_F),
      .SETTLE_FRAMES (SETTLE_F),
      .RESET_CFG     (7'b0000000),
      .VS_ACTIVE_LOW (1'b1)
   ) dut (
      .clk_sys                 (clk),
      .rst_n                   (rst_n),
      .req_scandoubler_disable (req_sd),
      .req_ypbpr               (req_ypbpr),
      .req_scanlines           (req_scan),
      .req_blend               (req_blend),
      .req_rotate              (req_rot),
      .vsync_in                (vsync),
      .scandoubler_disable     (sd_o),
      .ypbpr                   (ypbpr_o),
      .scanlines               (scan_o),
      .blend                   (blend_o),
      .rotate                  (rot_o),
      .blank                   (blank_o),
      .busy                    (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] dut_out();
      return {sd_o, ypbpr_o, scan_o, blend_o, rot_o, blank_o, busy_o};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_prev_req = 7'd0; m_acc = 7'd0; m_act = 7'd0;
      m_age = 0; m_quiet = 0; m_phase = M_IDLE; m_left = 0;
      m_vs_prev = 1'b1; m_blank = 1'b0; m_busy = 1'b0;
   endtask

   // One clock: advance the model on the same inputs the DUT sees, then compare.
   task automatic step(input string tag);
      logic [6:0] req, acc_old;
      bit tick;
      @(posedge clk);
      if (!rst_n) begin
         m_reset();
      end else begin
         req  = {req_sd, req_ypbpr, req_scan, req_blend, req_rot};
         tick = (m_vs_prev && !vsync) || (m_quiet == TIMEOUT - 1);
         m_quiet   = tick ? 0 : m_quiet + 1;
         m_vs_prev = vsync;
         acc_old   = m_acc;
         if (req != m_prev_req) begin
            m_age = 0;
         end else begin
            if (m_age >= STABLE - 1) m_acc = req;
            if (m_age < STABLE) m_age++;
         end
         m_prev_req = req;
         case (m_phase)
            M_IDLE: if (acc_old != m_act) begin
               m_busy = 1'b1;
               if (((acc_old ^ m_act) & 7'b1111000) != 7'd0) begin
                  m_phase = M_PRE; m_blank = 1'b1; m_left = PRE_F;
               end else begin
                  m_phase = M_FAST;
               end
            end
            M_FAST: if (tick) begin
               m_act = acc_old; m_phase = M_IDLE; m_busy = 1'b0;
            end
            M_PRE: begin
               if (m_left > 0 && tick) m_left--;
               if (m_left == 0) m_phase = M_APPLY;
            end
            M_APPLY: begin
               m_act = acc_old; m_left = SETTLE_F; m_phase = M_SETTLE;
            end
            default: begin
               if (acc_old != m_act) begin
                  m_phase = M_PRE; m_left = PRE_F;
               end else begin
                  if (m_left > 0 && tick) m_left--;
                  if (m_left == 0) begin
                     m_phase = M_IDLE; m_blank = 1'b0; m_busy = 1'b0;
                  end
               end
            end
         endcase
      end
      #1;
      check(tag, dut_out(), {m_act, m_blank, m_busy});
      if (vs_run) begin
         vs_ctr = (vs_ctr + 1) % VS_PER;
         vsync  = (vs_ctr >= 10);
      end else begin
         vsync = 1'b1;
      end
   endtask

   initial begin
      bit   seen;
      bit   ok;
      logic [6:0] r;
      m_reset();
      // reset state
      #2;
      check("reset_outputs", dut_out(), 9'd0);
      for (int i = 0; i < 3; i++) step("in_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 3 * VS_PER; i++) step("idle_after_reset");
      check("idle_3_frames", dut_out(), 9'd0);

      // fast change: rotate 0->2, never blanked
      req_rot = 2'd2;
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         step("rotate_fast");
         if (blank_o) seen = 1'b1;
      end
      check("rotate_applied", {7'd0, rot_o}, 9'd2);
      check("rotate_no_blank", {8'd0, seen}, 9'd0);

      // slow change: scanlines 0->2
      req_scan = 2'd2;
      for (int i = 0; i < 900; i++) step("scan_slow");
      check("scanlines_applied", {7'd0, scan_o}, 9'd2);
      check("scan_done_blank", {7'd0, blank_o, busy_o}, 9'd0);

      // glitch shorter than the filter: never accepted
      req_ypbpr = 1'b1;
      for (int i = 0; i < 3; i++) step("ypbpr_glitch");
      req_ypbpr = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step("ypbpr_glitch_after");
         if (blank_o || busy_o) seen = 1'b1;
      end
      check("glitch_ignored", {7'd0, ypbpr_o, seen}, 9'd0);

      // no vsync: timeout-driven ticks
      vs_run = 1'b0;
      req_sd = 1'b1;
      for (int i = 0; i < 3600; i++) step("timeout_ticks");
      check("sd_dis_applied", {7'd0, sd_o, blank_o}, 9'b000000010);
      vs_run = 1'b1; vs_ctr = 50;

      // new request during SETTLE keeps blank up and restarts
      req_ypbpr = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 1500 && !ok; i++) begin
         step("wait_settle");
         if (m_phase == M_SETTLE) ok = 1'b1;
      end
      check("reached_settle", {8'd0, ok}, 9'd1);
      req_scan = 2'd3;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         step("settle_restart");
         if (!blank_o) ok = 1'b1;
      end
      check("restart_blank_fell", {8'd0, ok}, 9'd1);
      check("restart_final_cfg", {5'd0, ypbpr_o, scan_o, blank_o}, 9'b000001110);

      // reset in the middle of PRE
      req_scan = 2'd1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         step("wait_pre");
         if (m_phase == M_PRE) ok = 1'b1;
      end
      check("reached_pre", {8'd0, ok}, 9'd1);
      step("in_pre");
      #2 rst_n = 1'b0;
      #1 check("reset_mid_pre", dut_out(), 9'd0);
      m_reset();
      step("held_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 900; i++) step("after_mid_reset");

      // random requests, mixing short glitches and held values
      for (int n = 0; n < 25; n++) begin
         r = 7'($urandom);
         {req_sd, req_ypbpr, req_scan, req_blend, req_rot} = r;
         for (int i = 0; i < int'($urandom_range(1, 300)); i++) step("random");
      end
      for (int i = 0; i < 3200; i++) step("random_drain");
      check("random_final", dut_out(), {r, 2'b00});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
